spike_rate_decoder: RTL and testbench

SPIKE_RATE_DECODER -- requirements
Module: spike_rate_decoder

---
 rtl/spike_rate_if.sv | 18 +
 rtl/spike_rate_decoder.sv | 78 +++++++
 tb/tb_spike_rate_decoder.sv | 137 +++++++++++++
 3 files changed

// File: rtl/spike_rate_if.sv
// spike_rate_if: spike input, enable and rate result handshake of the spike rate decoder
interface spike_rate_if;
    logic       enable;
    logic       spike;
    logic       rate_ready;
    logic       rate_valid;
    logic       overrun;
    logic [7:0] rate;
    logic [7:0] last_isi;
    modport master (
        input  enable, spike, rate_ready,
        output rate, rate_valid, last_isi, overrun
    );
    modport slave (
        output enable, spike, rate_ready,
        input  rate, rate_valid, last_isi, overrun
    );
endinterface

// File: rtl/spike_rate_decoder.sv
// spike_rate_decoder: windowed spike counting with a valid/ready result and inter-spike interval
module spike_rate_decoder #(
    parameter int WINDOW_CYCLES = 256
) (
    input logic           clk,
    input logic           reset,
    spike_rate_if.master  bus
);
    typedef enum logic {IDLE, COUNT} state_t;
    localparam logic [15:0] LAST = 16'(WINDOW_CYCLES - 1);
    state_t      state;
    logic [15:0] win_cnt;
    logic [7:0]  spk_cnt;
    logic [7:0]  isi_cnt;
    logic        armed;
    logic [7:0]  spk_next;
    logic        win_end;
    logic        accept;
    always_comb begin
        spk_next = (bus.spike && spk_cnt != 8'hff) ? spk_cnt + 8'd1 : spk_cnt;
        win_end  = state == COUNT && bus.enable && win_cnt == LAST;
        accept   = bus.rate_valid && bus.rate_ready;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            win_cnt        <= '0;
            spk_cnt        <= '0;
            isi_cnt        <= '0;
            armed          <= 1'b0;
            bus.rate       <= '0;
            bus.rate_valid <= 1'b0;
            bus.last_isi   <= '0;
            bus.overrun    <= 1'b0;
        end else begin
            // A finished window either lands in the output slot or is dropped as an overrun
            if (win_end) begin
                if (!bus.rate_valid || bus.rate_ready) begin
                    bus.rate       <= spk_next;
                    bus.rate_valid <= 1'b1;
                end else begin
                    bus.overrun    <= 1'b1;
                end
            end else if (accept) begin
                bus.rate_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (bus.enable) begin
                        state   <= COUNT;
                        win_cnt <= '0;
                        spk_cnt <= '0;
                    end
                end
                default: begin
                    if (!bus.enable) begin
                        state   <= IDLE;
                        win_cnt <= '0;
                        spk_cnt <= '0;
                        isi_cnt <= '0;
                        armed   <= 1'b0;
                    end else begin
                        win_cnt <= win_end ? '0 : win_cnt + 16'd1;
                        spk_cnt <= win_end ? '0 : spk_next;
                        // isi_cnt holds the distance from the last spike to the current cycle
                        if (bus.spike) begin
                            if (armed) bus.last_isi <= isi_cnt;
                            armed   <= 1'b1;
                            isi_cnt <= 8'd1;
                        end else if (isi_cnt != 8'hff) begin
                            isi_cnt <= isi_cnt + 8'd1;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_spike_rate_decoder.sv
// tb_spike_rate_decoder: two decoders (16- and 300-cycle windows) driven in lockstep against a timestamp model
module tb_spike_rate_decoder;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;
    spike_rate_if b0 ();
    spike_rate_if b1 ();
    spike_rate_decoder #(.WINDOW_CYCLES(16))  d0 (.clk(clk), .reset(reset), .bus(b0.master));
    spike_rate_decoder #(.WINDOW_CYCLES(300)) d1 (.clk(clk), .reset(reset), .bus(b1.master));
    int tests = 0;
    int fails = 0;
    int wlen [2] = '{16, 300};
    bit counting [2];
    bit armed [2];
    int pos [2], cnt [2], last_t [2];
    int m_rate [2], m_isi [2];
    bit m_valid [2], m_ovr [2];
    int t = 0;
    function automatic int sat(int x);
        return x > 255 ? 255 : x;
    endfunction
    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask
    task automatic step(bit r, bit en, bit sp, bit rdy);
        reset = r;
        b0.enable = en; b1.enable = en;
        b0.spike = sp;  b1.spike = sp;
        b0.rate_ready = rdy; b1.rate_ready = rdy;
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            bit fin;
            bit acc;
            int res;
            fin = 0;
            res = 0;
            acc = m_valid[i] && rdy;
            if (r) begin
                counting[i] = 0; armed[i] = 0; pos[i] = 0; cnt[i] = 0;
                m_rate[i] = 0; m_valid[i] = 0; m_isi[i] = 0; m_ovr[i] = 0;
            end else begin
                if (!counting[i]) begin
                    if (en) begin counting[i] = 1; pos[i] = 0; cnt[i] = 0; end
                end else if (!en) begin
                    counting[i] = 0; pos[i] = 0; cnt[i] = 0; armed[i] = 0;
                end else begin
                    if (sp) begin
                        if (armed[i]) m_isi[i] = sat(t - last_t[i]);
                        armed[i] = 1;
                        last_t[i] = t;
                        cnt[i]++;
                    end
                    if (pos[i] == wlen[i] - 1) begin
                        fin = 1; res = sat(cnt[i]); cnt[i] = 0; pos[i] = 0;
                    end else pos[i]++;
                end
                if (fin) begin
                    if (!m_valid[i] || rdy) begin m_rate[i] = res; m_valid[i] = 1; end
                    else m_ovr[i] = 1;
                end else if (acc) m_valid[i] = 0;
            end
        end
        t++;
        #1;
        chk("rate16", b0.rate, m_rate[0]);
        chk("valid16", b0.rate_valid, m_valid[0]);
        chk("isi16", b0.last_isi, m_isi[0]);
        chk("ovr16", b0.overrun, m_ovr[0]);
        chk("rate300", b1.rate, m_rate[1]);
        chk("valid300", b1.rate_valid, m_valid[1]);
        chk("isi300", b1.last_isi, m_isi[1]);
        chk("ovr300", b1.overrun, m_ovr[1]);
    endtask
    initial begin
        step(1, 0, 0, 0);
        step(1, 1, 1, 1);
        chk("rst_valid", b0.rate_valid, 0);
        chk("rst_rate", b1.rate, 0);
        // continuous spikes, always ready
        for (int k = 0; k < 700; k++) step(0, 1, 1, 1);
        chk("all_rate16", b0.rate, 16);
        chk("all_isi1", b0.last_isi, 1);
        chk("sat_rate300", b1.rate, 255);
        // spikes every 4 cycles, consumer stalled for two windows
        step(1, 0, 0, 0);
        for (int k = 0; k < 40; k++) step(0, 1, (k % 4) == 1, 0);
        chk("held_rate", b0.rate, 4);
        chk("held_valid", b0.rate_valid, 1);
        chk("overrun_set", b0.overrun, 1);
        step(0, 1, 0, 1);
        chk("drop_valid", b0.rate_valid, 0);
        step(0, 0, 0, 1);
        chk("overrun_sticky", b0.overrun, 1);
        // window end coinciding with acceptance
        step(1, 0, 0, 0);
        for (int k = 0; k <= 32; k++) step(0, 1, k <= 16 || k == 20 || k == 32, k == 32);
        chk("coinc_valid", b0.rate_valid, 1);
        chk("coinc_rate", b0.rate, 2);
        chk("coinc_ovr", b0.overrun, 0);
        // partial window discarded by enable drop
        step(1, 0, 0, 0);
        step(0, 1, 0, 1);
        for (int k = 1; k <= 10; k++) step(0, 1, k == 2 || k == 5 || k == 8, 1);
        step(0, 0, 1, 1);
        chk("partial_none", b0.rate_valid, 0);
        step(0, 1, 1, 1);
        for (int j = 0; j < 16; j++) step(0, 1, j == 3 || j == 9, 1);
        chk("reen_valid", b0.rate_valid, 1);
        chk("reen_rate", b0.rate, 2);
        // ISI measurement
        step(1, 0, 0, 0);
        step(0, 1, 0, 1);
        step(0, 1, 1, 1);
        for (int k = 0; k < 4; k++) step(0, 1, 0, 1);
        step(0, 1, 1, 1);
        chk("isi5", b0.last_isi, 5);
        for (int k = 0; k < 400; k++) step(0, 1, 0, 1);
        step(0, 1, 1, 1);
        chk("isi255", b0.last_isi, 255);
        for (int k = 0; k < 7; k++) step(0, 1, 1, 0);
        step(1, 1, 1, 1);
        chk("rst_mid_rate", b0.rate, 0);
        chk("rst_mid_isi", b0.last_isi, 0);
        chk("rst_mid_valid", b0.rate_valid, 0);
        chk("rst_mid_ovr", b0.overrun, 0);
        // randomized traffic
        for (int k = 0; k < 1500; k++)
            step($urandom_range(0, 199) == 0, $urandom_range(0, 24) != 0,
                 $urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
